// File: rtl/serial_record_loader_if.sv
// Serial input link and dataset RAM write port of the record loader, grouped as one bundle.
// Latency: none, wires only.
// Backpressure: ser_ready paces the serial side; the RAM write side has no backpressure.
interface serial_record_loader_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 256
);
    logic                  ser_valid;
    logic                  ser_bit;
    logic                  ser_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    // Loader side: consumes serial bits, drives the RAM write port.
    modport master (
        input  ser_valid,
        input  ser_bit,
        output ser_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    // Environment side: serial front-end plus RAM.
    modport slave (
        output ser_valid,
        output ser_bit,
        input  ser_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/serial_record_loader.sv
// Bit-serial deserializer: packs feat+1 elements per record, LSB of element 0 first, into one RAM word.
// Latency: wr_en is high the cycle after the last bit of a record is accepted.
// Backpressure: ser_ready is low outside LOAD; stalls (ser_valid=0) hold all state.
// Optional SERIAL_PARITY_EN: each record carries one trailing even-parity bit; mismatches set sticky parity_err.
module serial_record_loader #(
    parameter int ADDR_WIDTH   = 12,
    parameter int ELEM_WIDTH   = 16,
    parameter int MAX_FEATURES = 15,
    parameter int FEAT_BITS    = 4,
    parameter int DATA_WIDTH   = ELEM_WIDTH * (MAX_FEATURES + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num_dp,
    input  logic [FEAT_BITS-1:0]  feat,
    serial_record_loader_if.master bus,
    output logic                  busy,
    output logic                  last_rec,
    output logic                  done,
    output logic                  parity_err
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 2);
    localparam int IDX_W = $clog2(DATA_WIDTH);

`ifdef SERIAL_PARITY_EN
    localparam logic [CNT_W-1:0] PAR_BITS = CNT_W'(1);
`else
    localparam logic [CNT_W-1:0] PAR_BITS = CNT_W'(0);
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q,    state_d;
    logic [ADDR_WIDTH-1:0] num_dp_q,   num_dp_d;
    logic [FEAT_BITS-1:0]  feat_q,     feat_d;
    logic [ADDR_WIDTH-1:0] rec_addr_q, rec_addr_d;
    logic [CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;

    logic [FEAT_BITS-1:0]  feat_clamp;
    logic [CNT_W-1:0]      rec_bits;
    logic [CNT_W-1:0]      base;
    logic [CNT_W-1:0]      last_bit;
    logic [CNT_W-1:0]      idx;
    logic                  data_bit;
    logic                  accept;
    logic                  start_ok;

    // Record geometry derived from the latched feature count; the record is packed against the MSB end.
    always_comb begin
        feat_clamp = (32'(feat) > MAX_FEATURES) ? FEAT_BITS'(MAX_FEATURES) : feat;
        rec_bits   = CNT_W'(ELEM_WIDTH * (32'(feat_q) + 1));
        base       = CNT_W'(DATA_WIDTH) - rec_bits;
        last_bit   = rec_bits - CNT_W'(1) + PAR_BITS;
        idx        = base + bit_cnt_q;
        data_bit   = (bit_cnt_q < rec_bits);
        accept     = (state_q == S_LOAD) && bus.ser_valid;
        start_ok   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    // Next-state logic for the load sequencer, shift register and counters.
    always_comb begin
        state_d    = state_q;
        num_dp_d   = num_dp_q;
        feat_d     = feat_q;
        rec_addr_d = rec_addr_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d    = S_LOAD;
                    num_dp_d   = num_dp;
                    feat_d     = feat_clamp;
                    rec_addr_d = '0;
                    bit_cnt_d  = '0;
                    shift_d    = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    // The trailing parity bit, when present, is counted but never stored.
                    if (data_bit) begin
                        shift_d[idx[IDX_W-1:0]] = bus.ser_bit;
                    end
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == last_bit) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (rec_addr_q == num_dp_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_LOAD;
                    rec_addr_d = rec_addr_q + 1'b1;
                    bit_cnt_d  = '0;
                    shift_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; synchronous reset abandons any load in progress.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            num_dp_q   <= '0;
            feat_q     <= '0;
            rec_addr_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            num_dp_q   <= num_dp_d;
            feat_q     <= feat_d;
            rec_addr_q <= rec_addr_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

`ifdef SERIAL_PARITY_EN
    logic par_acc_q;
    logic parity_err_q;

    // Running XOR of the record's data bits; the parity bit must make the total even.
    always_ff @(posedge CLK) begin
        if (RST || start_ok) begin
            par_acc_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else if (state_q == S_WRITE) begin
            par_acc_q    <= 1'b0;
        end else if (accept) begin
            if (data_bit) begin
                par_acc_q <= par_acc_q ^ bus.ser_bit;
            end else if (bus.ser_bit != par_acc_q) begin
                parity_err_q <= 1'b1;
            end
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign bus.ser_ready = (state_q == S_LOAD);
    assign bus.wr_en     = (state_q == S_WRITE);
    assign bus.wr_addr   = rec_addr_q;
    assign bus.wr_data   = shift_q;
    assign busy          = (state_q == S_LOAD) || (state_q == S_WRITE);
    assign done          = (state_q == S_DONE);
    // Final record is flagged once its first bit is in, and stays flagged through its write.
    assign last_rec      = busy && (rec_addr_q == num_dp_q) &&
                           ((state_q == S_WRITE) || (bit_cnt_q != '0));
endmodule

// File: tb/tb_serial_record_loader.sv
// Randomized bench for serial_record_loader: driver pushes expected records, a monitor checks every write.
// Latency: monitor expects wr_en exactly one cycle after the last accepted bit of each record.
// Backpressure: the driver retries each bit until ser_valid and ser_ready coincide.
module tb_serial_record_loader;
    localparam int AW = 12;
    localparam int EW = 16;
    localparam int MF = 15;
    localparam int FB = 4;
    localparam int DW = EW * (MF + 1);
`ifdef SERIAL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic [AW-1:0] num_dp;
    logic [FB-1:0] feat;
    logic          busy, last_rec, done, parity_err;

    serial_record_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    serial_record_loader #(
        .ADDR_WIDTH(AW), .ELEM_WIDTH(EW), .MAX_FEATURES(MF), .FEAT_BITS(FB)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .num_dp(num_dp), .feat(feat),
        .bus(bus_if), .busy(busy), .last_rec(last_rec), .done(done), .parity_err(parity_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            last;
        bit            perr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   rec_len  = 32;
    int   acc      = 0;
    bit   pend     = 1'b0;
    bit   exp_done = 1'b0;
    bit   toggle   = 1'b1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: counts accepted bits, checks write latency and pops the scoreboard on each wr_en.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            #1;
            if (RST) begin
                acc = 0; pend = 1'b0; exp_done = 1'b0;
            end else begin
                if (exp_done) begin
                    chk("done_after_last", DW'(done), DW'(1));
                    chk("busy_in_done", DW'(busy), DW'(0));
                    exp_done = 1'b0;
                end
                if (pend || bus_if.wr_en) begin
                    chk("wr_en_latency", DW'(bus_if.wr_en), DW'(pend));
                    if (bus_if.wr_en) begin
                        if (exp_q.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL unexpected_write: addr %0h with empty scoreboard", bus_if.wr_addr);
                        end else begin
                            e = exp_q.pop_front();
                            chk("wr_addr", DW'(bus_if.wr_addr), DW'(e.addr));
                            chk("wr_data", bus_if.wr_data, e.data);
                            chk("last_rec_at_write", DW'(last_rec), DW'(e.last));
                            chk("parity_err_at_write", DW'(parity_err), DW'(e.perr));
                            chk("ser_ready_in_write", DW'(bus_if.ser_ready), DW'(0));
                            if (e.last) exp_done = 1'b1;
                        end
                    end
                    pend = 1'b0;
                end
                if (bus_if.ser_valid && bus_if.ser_ready) begin
                    acc++;
                    if (acc == rec_len) begin
                        acc = 0; pend = 1'b1;
                    end
                end
            end
        end
    end

    // Offer one bit until it is taken; mode 0 continuous, 1 alternating valid, 2 random stalls.
    task automatic send_bit(input bit b, input int mode);
        int guard = 0;
        bit go;
        forever begin
            @(negedge CLK);
            guard++;
            case (mode)
                0:       go = 1'b1;
                1:       begin go = toggle; toggle = ~toggle; end
                default: go = ($urandom_range(0, 2) != 0);
            endcase
            bus_if.ser_valid = go;
            bus_if.ser_bit   = b;
            if (go && bus_if.ser_ready) break;
            if (guard > 1000) begin
                checks++; failures++;
                $display("FAIL send_timeout: ser_ready never seen");
                break;
            end
        end
    endtask

    task automatic run_load(input int nd, input int ft, input int mode, input bit fixed,
                            input bit bad0, input bit glitch);
        int            fl, base, guard;
        logic [DW-1:0] word, tmp;
        logic [EW-1:0] el [0:MF];
        bit            p, bad, perr_exp;
        perr_exp = 1'b0;
        fl       = (ft > MF) ? MF : ft;
        base     = DW - EW * (fl + 1);
        rec_len  = EW * (fl + 1) + PAR;
        @(negedge CLK);
        bus_if.ser_valid = 1'b0;
        start = 1'b1; num_dp = AW'(nd); feat = FB'(ft);
        @(negedge CLK);
        start = 1'b0;
        chk("start_busy", DW'(busy), DW'(1));
        chk("start_done_clear", DW'(done), DW'(0));
        chk("start_perr_clear", DW'(parity_err), DW'(0));
        for (int r = 0; r <= nd; r++) begin
            word = '0; p = 1'b0;
            for (int k = 0; k <= fl; k++) begin
                if (fixed) el[k] = (k == 0) ? ((r == 0) ? 16'hAAAA : 16'h5555) : EW'(r + 1);
                else       el[k] = EW'($urandom);
                tmp  = DW'(el[k]);
                word = word | (tmp << (base + k * EW));
                p    = p ^ (^el[k]);
            end
            bad      = bad0 && (r == 0) && (PAR == 1);
            perr_exp = perr_exp | bad;
            exp_q.push_back('{addr: AW'(r), data: word, last: (r == nd), perr: perr_exp});
            for (int k = 0; k <= fl; k++) begin
                for (int b = 0; b < EW; b++) begin
                    if (glitch && r == 0 && k == 0 && b == 5) begin
                        @(negedge CLK);
                        bus_if.ser_valid = 1'b0;
                        start = 1'b1; num_dp = AW'(nd + 3); feat = FB'(ft ^ 1);
                        @(negedge CLK);
                        start = 1'b0; num_dp = AW'(nd); feat = FB'(ft);
                    end
                    send_bit(el[k][b], mode);
                    if (k == 0 && b == 0) begin
                        @(posedge CLK); #1;
                        bus_if.ser_valid = 1'b0;
                        chk("last_rec_first_bit", DW'(last_rec), DW'(r == nd));
                    end
                end
            end
            if (PAR == 1) send_bit(p ^ bad, mode);
        end
        @(posedge CLK); #1;
        bus_if.ser_valid = 1'b0;
        guard = 0;
        while (!done && guard < 3000) begin
            @(negedge CLK);
            guard++;
        end
        @(negedge CLK);
        chk("run_done", DW'(done), DW'(1));
        chk("scoreboard_drained", DW'(exp_q.size()), DW'(0));
        chk("done_hold_addr", DW'(bus_if.wr_addr), DW'(nd));
        chk("done_hold_data", bus_if.wr_data, word);
        chk("done_last_rec_low", DW'(last_rec), DW'(0));
        chk("done_perr_sticky", DW'(parity_err), DW'(perr_exp));
    endtask

    initial begin : timeout
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        RST = 1'b1; start = 1'b0; num_dp = '0; feat = '0;
        bus_if.ser_valid = 1'b0; bus_if.ser_bit = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_ser_ready", DW'(bus_if.ser_ready), DW'(0));
        RST = 1'b0;

        // Abandon a partially loaded record with a 3-cycle reset.
        rec_len = 32;
        @(negedge CLK);
        start = 1'b1; num_dp = AW'(1); feat = FB'(1);
        @(negedge CLK);
        start = 1'b0;
        for (int b = 0; b < 10; b++) send_bit(b[0], 0);
        @(negedge CLK);
        bus_if.ser_valid = 1'b0;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_mid_wr_en", DW'(bus_if.wr_en), DW'(0));
        chk("rst_mid_busy", DW'(busy), DW'(0));
        chk("rst_mid_done", DW'(done), DW'(0));
        chk("rst_mid_ser_ready", DW'(bus_if.ser_ready), DW'(0));
        chk("rst_mid_last_rec", DW'(last_rec), DW'(0));
        chk("rst_mid_parity_err", DW'(parity_err), DW'(0));
        chk("rst_mid_wr_addr", DW'(bus_if.wr_addr), DW'(0));
        chk("rst_mid_wr_data", bus_if.wr_data, DW'(0));
        RST = 1'b0;

        run_load(1, 1, 0, 1'b1, 1'b0, 1'b0);   // basic fixed records
        run_load(1, 1, 1, 1'b1, 1'b0, 1'b0);   // same records, alternating valid
        run_load(2, 15, 2, 1'b0, 1'b0, 1'b0);  // full-width records, random stalls
        run_load(0, 0, 0, 1'b0, 1'b0, 1'b0);   // single one-element record
        run_load(2, 3, 0, 1'b0, 1'b0, 1'b1);   // start during LOAD ignored
        run_load(2, 5, 2, 1'b0, 1'b1, 1'b0);   // restart from DONE, bad parity on record 0
        run_load(1, 9, 2, 1'b0, 1'b0, 1'b0);   // restart clears parity_err

        repeat (3) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_record_loader.md
Name: serial_record_loader

Overview:
- Bit-serial deserializer that assembles training-set records (up to MAX_FEATURES feature elements plus one y element) and writes each record as one wide word into the dataset RAM.
- Sits between the serial link front-end and the dataset RAM write port.
- Successor to the single-width loader: parametrised element width and record count, ser_valid/ser_ready handshake, explicit single-cycle RAM write strobe, start/busy/done control and last-record signalling.

Parameters:
- ADDR_WIDTH, 12, RAM address width; maximum record count is 2^ADDR_WIDTH.
- ELEM_WIDTH, 16, bits per feature or y element.
- MAX_FEATURES, 15, maximum number of feature elements per record.
- FEAT_BITS, 4, width of feat input; must satisfy 2^FEAT_BITS > MAX_FEATURES.
- DATA_WIDTH, ELEM_WIDTH*(MAX_FEATURES+1), RAM word width.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- num_dp  in  ADDR_WIDTH  address of the last record; record count = num_dp+1. Latched on start.
- feat  in  FEAT_BITS  number of feature elements; a record holds feat+1 elements. Latched on start.
- ser_valid  in  1  ser_bit is valid this cycle.
- ser_bit  in  1  serial data; LSB of element 0 first.
- ser_ready  out  1  loader accepts a bit this cycle.
- wr_en  out  1  RAM write strobe, one cycle per record.
- wr_addr  out  ADDR_WIDTH  RAM write address.
- wr_data  out  DATA_WIDTH  record word.
- busy  out  1  high in LOAD or WRITE.
- last_rec  out  1  high from the first accepted bit of record num_dp until DONE.
- done  out  1  high in DONE.
- parity_err  out  1  sticky parity error (see Optional Feature).

Behaviour:
Reset:
- RST in any state forces IDLE on the next edge.
- All outputs 0; shift register, bit counter and address counter cleared.
- A load in progress is abandoned and no wr_en is issued.

Latch rules:
- feat_l = min(feat, MAX_FEATURES).
- REC_BITS = ELEM_WIDTH*(feat_l+1).
- BASE = DATA_WIDTH - REC_BITS.

State IDLE:
- ser_ready=0.
- On start: latch num_dp and feat_l, rec_addr=0, bit_cnt=0, clear the shift register, go to LOAD.

State LOAD:
- ser_ready=1.
- Each cycle with ser_valid=1: shift_reg[BASE+bit_cnt] <= ser_bit, bit_cnt increments.
- Cycles with ser_valid=0 hold all state.
- When the accepted bit has bit_cnt == REC_BITS-1, go to WRITE.
- Bits below BASE stay 0. Element k occupies [BASE+k*ELEM_WIDTH +: ELEM_WIDTH]; the y element is element feat_l, in the MSB slot.

State WRITE (exactly 1 cycle):
- wr_en=1, wr_addr=rec_addr, wr_data=shift_reg, ser_ready=0.
- Next state:
  - rec_addr == num_dp: go to DONE.
  - Otherwise: rec_addr+1, bit_cnt=0, clear the shift register, back to LOAD.
- Latency: wr_en is asserted on the cycle after the last bit of a record is accepted.

State DONE:
- done=1, ser_ready=0, busy=0, last_rec=0.
- wr_addr/wr_data hold their last values (never high-Z).
- start re-enters LOAD with a fresh latch and clears parity_err.

Outside WRITE:
- wr_en=0; wr_addr=rec_addr; wr_data=shift_reg.

Boundaries:
- start during LOAD/WRITE is ignored.
- num_dp=0: exactly one record is written.
- num_dp=2^ADDR_WIDTH-1: all addresses are written; no wrap.
- feat=0: 1-element records occupying the MSB slot.
- ser_valid in IDLE/DONE is ignored.

Optional Feature:
- Macro: SERIAL_PARITY_EN.
- Defined:
  - Each record is followed by one even-parity bit, so LOAD accepts REC_BITS+1 bits.
  - The parity bit is not stored.
  - On mismatch, parity_err is set (sticky until RST or start). The record is still written.
  - WRITE follows acceptance of the parity bit.
- Undefined:
  - No parity bit is consumed.
  - parity_err is tied 0.

Test Plan:
- Reset values: RST held 3 cycles mid-LOAD -> all outputs 0, state IDLE, no wr_en, subsequent start loads from address 0.
- Basic load: feat=1, num_dp=1, ser_valid=1 continuously, records 0x0001_AAAA and 0x0002_5555 -> two wr_en pulses at cycles 33 and 66 after start.
  - wr_addr 0 then 1.
  - wr_data[255:224] = 0x0001AAAA then 0x00025555, lower bits 0.
  - done rises the cycle after the second write.
- Stalls: same stimulus with ser_valid toggling 1010... -> identical wr_data/wr_addr; each wr_en one cycle after the 32nd accepted bit; no writes during stalls.
- Limits:
  - feat=15 -> full 256-bit record.
  - feat=0, num_dp=0 -> single write of wr_data[255:240], done; last_rec high from the first bit.
- Control: start asserted during LOAD is ignored; start in DONE with num_dp=2 -> three new writes at addresses 0..2, done cleared then reasserted.
- SERIAL_PARITY_EN: record with a wrong parity bit -> parity_err=1, record still written; the next correct record leaves parity_err at 1; start clears it.
